// File: rtl/student_pc_seq.sv
// -----------------------------------------------------------------------------
// student_pc_seq
// Hack-style program counter with an integrated jump-condition unit.
// The zero flag of the incoming ALU result is derived through an OR-reduction
// tree made of student_or8way / student_or cells; the negative flag is the sign
// bit. A valid/ready command handshake paces PC updates, and a small FSM covers
// boot after reset and halt on the "unconditional jump to self" idiom.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   clr        in   1   synchronous clear: pc <= RESET_PC, flags cleared, -> BOOT
//   cmd_valid  in   1   command present this cycle
//   cmd_ready  out  1   command accepted this cycle (RUN state only)
//   jmp        in   3   {lt, eq, gt} jump mask
//   target     in   16  jump target
//   alu_out    in   16  ALU result the condition is evaluated on
//   pc         out  16  current program counter
//   pc_valid   out  1   pc meaningful (RUN or HALT)
//   taken      out  1   last accepted command jumped
//   zr         out  1   last accepted alu_out was zero
//   ng         out  1   last accepted alu_out was negative
//   halted     out  1   FSM is in HALT
// -----------------------------------------------------------------------------

// Two-input OR cell; the basic gate of the zero-detect tree.
module student_or (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a | b;
endmodule

// Eight-input OR built as a three-level tree of student_or cells.
module student_or8way (
    input  logic [7:0] a,
    output logic       y
);
    logic [3:0] lvl1_s;
    logic [1:0] lvl2_s;

    student_or u_or_l1_0 (.a(a[0]),      .b(a[1]),      .y(lvl1_s[0]));
    student_or u_or_l1_1 (.a(a[2]),      .b(a[3]),      .y(lvl1_s[1]));
    student_or u_or_l1_2 (.a(a[4]),      .b(a[5]),      .y(lvl1_s[2]));
    student_or u_or_l1_3 (.a(a[6]),      .b(a[7]),      .y(lvl1_s[3]));
    student_or u_or_l2_0 (.a(lvl1_s[0]), .b(lvl1_s[1]), .y(lvl2_s[0]));
    student_or u_or_l2_1 (.a(lvl1_s[2]), .b(lvl1_s[3]), .y(lvl2_s[1]));
    student_or u_or_l3   (.a(lvl2_s[0]), .b(lvl2_s[1]), .y(y));
endmodule

module student_pc_seq #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int unsigned BOOT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  jmp,
    input  logic [15:0] target,
    input  logic [15:0] alu_out,
    output logic [15:0] pc,
    output logic        pc_valid,
    output logic        taken,
    output logic        zr,
    output logic        ng,
    output logic        halted
);

    localparam int unsigned   BCW       = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BCW-1:0] BOOT_LAST = BCW'(BOOT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [BCW-1:0]  boot_cnt_r, boot_cnt_nxt_s;
    logic [15:0]     pc_r, pc_nxt_s;
    logic            taken_r, taken_nxt_s;
    logic            zr_r, zr_nxt_s;
    logic            ng_r, ng_nxt_s;
    logic            cmd_ready_r, pc_valid_r, halted_r;

    logic            or_lo_s, or_hi_s, nonzero_s;
    logic            zr_c_s, ng_c_s, cond_s;

    // Zero detect through the OR tree: low byte, high byte, then combine.
    student_or8way u_or_lo (.a(alu_out[7:0]),  .y(or_lo_s));
    student_or8way u_or_hi (.a(alu_out[15:8]), .y(or_hi_s));
    student_or     u_or_nz (.a(or_lo_s), .b(or_hi_s), .y(nonzero_s));

    assign zr_c_s = ~nonzero_s;
    assign ng_c_s = alu_out[15];
    // gt is "neither zero nor negative"; 000 never jumps, 111 always jumps.
    assign cond_s = (jmp[2] & ng_c_s) | (jmp[1] & zr_c_s) | (jmp[0] & ~zr_c_s & ~ng_c_s);

    // Next-state and next-datapath decode; clr overrides any command.
    always_comb begin
        state_nxt_s    = state_r;
        boot_cnt_nxt_s = boot_cnt_r;
        pc_nxt_s       = pc_r;
        taken_nxt_s    = taken_r;
        zr_nxt_s       = zr_r;
        ng_nxt_s       = ng_r;
        if (clr) begin
            state_nxt_s    = ST_BOOT;
            boot_cnt_nxt_s = '0;
            pc_nxt_s       = RESET_PC;
            taken_nxt_s    = 1'b0;
            zr_nxt_s       = 1'b0;
            ng_nxt_s       = 1'b0;
        end else begin
            case (state_r)
                ST_BOOT: begin
                    pc_nxt_s = RESET_PC;
                    if (boot_cnt_r == BOOT_LAST) begin
                        state_nxt_s    = ST_RUN;
                        boot_cnt_nxt_s = '0;
                    end else begin
                        boot_cnt_nxt_s = boot_cnt_r + BCW'(1);
                    end
                end
                ST_RUN: begin
                    if (cmd_valid) begin
                        pc_nxt_s    = cond_s ? target : (pc_r + 16'd1);
                        taken_nxt_s = cond_s;
                        zr_nxt_s    = zr_c_s;
                        ng_nxt_s    = ng_c_s;
                        // Only an unconditional jump to the current pc halts;
                        // conditional self-loops keep running.
                        if ((jmp == 3'b111) && (target == pc_r)) begin
                            state_nxt_s = ST_HALT;
                        end else begin
                            state_nxt_s = ST_RUN;
                        end
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_HALT: begin
                    state_nxt_s = ST_HALT;
                end
                default: begin
                    state_nxt_s    = ST_BOOT;
                    boot_cnt_nxt_s = '0;
                    pc_nxt_s       = RESET_PC;
                    taken_nxt_s    = 1'b0;
                    zr_nxt_s       = 1'b0;
                    ng_nxt_s       = 1'b0;
                end
            endcase
        end
    end

    // State, datapath and status-flag registers; flags decode the next state so
    // they line up with the state register cycle for cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_BOOT;
            boot_cnt_r  <= '0;
            pc_r        <= RESET_PC;
            taken_r     <= 1'b0;
            zr_r        <= 1'b0;
            ng_r        <= 1'b0;
            cmd_ready_r <= 1'b0;
            pc_valid_r  <= 1'b0;
            halted_r    <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            boot_cnt_r  <= boot_cnt_nxt_s;
            pc_r        <= pc_nxt_s;
            taken_r     <= taken_nxt_s;
            zr_r        <= zr_nxt_s;
            ng_r        <= ng_nxt_s;
            cmd_ready_r <= (state_nxt_s == ST_RUN);
            pc_valid_r  <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_HALT);
            halted_r    <= (state_nxt_s == ST_HALT);
        end
    end

    assign pc        = pc_r;
    assign taken     = taken_r;
    assign zr        = zr_r;
    assign ng        = ng_r;
    assign cmd_ready = cmd_ready_r;
    assign pc_valid  = pc_valid_r;
    assign halted    = halted_r;

endmodule

// File: tb/tb_student_pc_seq.sv
// -----------------------------------------------------------------------------
// tb_student_pc_seq
// Scoreboard bench for student_pc_seq. The driver computes the expected result
// of every accepted command from a flag-level reference model (signed compare
// of alu_out, modular pc arithmetic) and queues it; an independent monitor pops
// and compares one entry after every clock edge at which a command was taken.
// -----------------------------------------------------------------------------
module tb_student_pc_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clr = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [2:0]  jmp = 3'b000;
    logic [15:0] target = 16'h0000;
    logic [15:0] alu_out = 16'h0000;
    logic        cmd_ready;
    logic [15:0] pc;
    logic        pc_valid, taken, zr, ng, halted;

    student_pc_seq #(.RESET_PC(16'h0000), .BOOT_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .jmp(jmp), .target(target), .alu_out(alu_out),
        .pc(pc), .pc_valid(pc_valid), .taken(taken), .zr(zr), .ng(ng),
        .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] pc;
        logic        taken;
        logic        zr;
        logic        ng;
        logic        halted;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    logic [15:0] m_pc = 16'h0000;
    logic        m_halted = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: any edge that took a command must be matched by a queued result.
    always @(posedge clk) begin
        if (rst_n && !clr && cmd_valid && cmd_ready) begin
            #1;
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: accept with empty scoreboard (t=%0t)", $time);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_pc",     pc,     mon_e.pc);
                check("sb_taken",  taken,  mon_e.taken);
                check("sb_zr",     zr,     mon_e.zr);
                check("sb_ng",     ng,     mon_e.ng);
                check("sb_halted", halted, mon_e.halted);
            end
        end
    end

    // Drive one command at a negedge; predict its effect if it will be taken.
    task automatic send(input logic [2:0] j, input logic [15:0] t, input logic [15:0] a);
        logic is_zero, is_neg, is_pos, jump;
        exp_t e;
        cmd_valid = 1'b1;
        jmp       = j;
        target    = t;
        alu_out   = a;
        if (cmd_ready === 1'b1) begin
            is_zero  = (a == 16'd0);
            is_neg   = ($signed(a) < 0);
            is_pos   = ($signed(a) > 0);
            jump     = (j[2] && is_neg) || (j[1] && is_zero) || (j[0] && is_pos);
            e.pc     = jump ? t : (m_pc + 16'd1);
            e.taken  = jump;
            e.zr     = is_zero;
            e.ng     = is_neg;
            e.halted = (j == 3'b111) && (t == m_pc);
            m_pc     = e.pc;
            m_halted = e.halted;
            sb_q.push_back(e);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        check(name, cmd_ready, 1);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m_pc     = 16'h0000;
        m_halted = 1'b0;
        check("clr_pc",        pc,        16'h0000);
        check("clr_taken",     taken,     0);
        check("clr_halted",    halted,    0);
        check("clr_cmd_ready", cmd_ready, 0);
        check("clr_pc_valid",  pc_valid,  0);
        wait_ready("clr_to_run");
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [15:0] a, t;
        logic [2:0]  j;

        // 1: reset and boot
        #1 rst_n = 1'b0;
        #1;
        check("rst_pc",        pc,        16'h0000);
        check("rst_pc_valid",  pc_valid,  0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_taken",     taken,     0);
        check("rst_zr",        zr,        0);
        check("rst_ng",        ng,        0);
        check("rst_halted",    halted,    0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 check("boot_cmd_ready", cmd_ready, 0);
        @(negedge clk);
        check("run_cmd_ready", cmd_ready, 1);
        check("run_pc_valid",  pc_valid,  1);
        check("run_pc",        pc,        16'h0000);

        // 2: five sequential increments
        for (int i = 0; i < 5; i++) send(3'b000, 16'h0777, 16'h0001);
        check("seq_pc5", pc, 16'h0005);

        // 3: JEQ taken on zero, not taken on negative
        send(3'b010, 16'h0040, 16'h0000);
        send(3'b010, 16'h0040, 16'h8000);

        // hold without command
        @(negedge clk);
        check("idle_hold_pc", pc, m_pc);

        // 4: wrap at 16'hFFFF
        send(3'b111, 16'hFFFF, 16'h1234);
        send(3'b000, 16'h0000, 16'h0005);
        check("wrap_pc", pc, 16'h0000);

        // conditional jump to self does not halt
        send(3'b000, 16'h0000, 16'h0001);
        send(3'b010, m_pc, 16'h0000);
        check("cond_self_no_halt", halted, 0);

        // 5: unconditional jump to self halts and freezes
        send(3'b111, 16'h0010, 16'h0003);
        send(3'b111, 16'h0010, 16'hF000);
        check("halt_halted",    halted,    1);
        check("halt_cmd_ready", cmd_ready, 0);
        check("halt_pc_valid",  pc_valid,  1);
        cmd_valid = 1'b1;
        jmp       = 3'b000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("halt_frozen_pc", pc, 16'h0010);
        end
        cmd_valid = 1'b0;
        do_clr();

        // 6: clr beats a same-cycle command
        send(3'b100, 16'h1234, 16'hFFFF);
        cmd_valid = 1'b1;
        jmp       = 3'b111;
        target    = 16'h2222;
        clr       = 1'b1;
        @(negedge clk);
        clr       = 1'b0;
        cmd_valid = 1'b0;
        m_pc      = 16'h0000;
        m_halted  = 1'b0;
        check("clrcmd_pc",    pc,    16'h0000);
        check("clrcmd_taken", taken, 0);
        check("clrcmd_ng",    ng,    0);
        wait_ready("clrcmd_to_run");

        // randomized commands against the reference model
        for (int i = 0; i < 400; i++) begin
            if (m_halted) begin
                do_clr();
            end else if ($urandom_range(0, 7) == 0) begin
                @(negedge clk);
                check("rnd_idle_pc", pc, m_pc);
            end else begin
                case ($urandom_range(0, 3))
                    0:       a = 16'h0000;
                    1:       a = 16'h8000 | 16'($urandom);
                    default: a = 16'($urandom);
                endcase
                j = 3'($urandom);
                t = ($urandom_range(0, 9) == 0) ? m_pc : 16'($urandom);
                send(j, t, a);
            end
        end

        // async reset mid-stream
        if (m_halted) do_clr();
        send(3'b111, 16'hABCD, 16'h0001);
        cmd_valid = 1'b1;
        jmp       = 3'b111;
        target    = 16'h5555;
        #2 rst_n = 1'b0;
        #1;
        check("arst_pc",        pc,        16'h0000);
        check("arst_taken",     taken,     0);
        check("arst_zr",        zr,        0);
        check("arst_ng",        ng,        0);
        check("arst_cmd_ready", cmd_ready, 0);
        check("arst_pc_valid",  pc_valid,  0);
        check("arst_halted",    halted,    0);
        @(negedge clk);
        check("arst_hold_pc", pc, 16'h0000);
        cmd_valid = 1'b0;
        rst_n     = 1'b1;
        m_pc      = 16'h0000;
        m_halted  = 1'b0;
        wait_ready("arst_to_run");
        send(3'b001, 16'h0099, 16'h0007);
        send(3'b000, 16'h0000, 16'h0000);
        @(negedge clk);
        check("sb_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
